// File: rtl/alu_mw_seq.sv
// Multi-word arithmetic sequencer. It drives a shared single-word ALU one word per
// cycle, least-significant word first, and chains the carry and aggregates the flags.
`ifndef ADD
`define ADD 4'h0
`endif

module alu_mw_seq #(
  parameter int DataWidth = 16,
  parameter int FlagBits  = 4,
  parameter int Words     = 4
) (
  input  logic                           Clk,
  input  logic                           nRst,
  input  logic                           Start,
  input  logic [1:0]                     ReqOp,
  input  logic                           CarryIn,
  input  logic [Words*DataWidth-1:0]     OpA,
  input  logic [Words*DataWidth-1:0]     OpB,
  output logic                           Ready,
  output logic                           Busy,
  output logic                           Done,
  output logic [Words*DataWidth-1:0]     Result,
  output logic [FlagBits-1:0]            Flags,
  output logic [DataWidth-1:0]           ALU_A,
  output logic [DataWidth-1:0]           ALU_B,
  output logic [FlagBits-1:0]            ALU_IFlags,
  output logic [3:0]                     ALU_FuncOp,
  input  logic [DataWidth-1:0]           ALU_Y,
  input  logic [FlagBits-1:0]            ALU_OFlags
);

  localparam int IdxW  = $clog2(Words);
  localparam int FlagZ = 0;
  localparam int FlagC = 1;
  localparam int FlagN = 2;
  localparam int FlagV = 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_ADC, OP_SUB, OP_CMP} op_t;

  state_t                       state_q;
  op_t                          op_q;
  logic [IdxW-1:0]              idx_q;
  logic [Words*DataWidth-1:0]   a_q;
  logic [Words*DataWidth-1:0]   b_q;
  logic [Words*DataWidth-1:0]   result_q;
  logic [FlagBits-1:0]          flags_q;
  logic [FlagBits-1:0]          flags_d;
  logic                         carry_q;
  logic                         zero_q;
  logic                         carry_start;
  logic [DataWidth-1:0]         a_word;
  logic [DataWidth-1:0]         b_word;

  assign a_word = a_q[idx_q*DataWidth +: DataWidth];
  assign b_word = b_q[idx_q*DataWidth +: DataWidth];

  // Subtraction runs as A + ~B + 1 through the ALU's ADD, since its SUB ignores carry-in.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_IFlags = '0;
    if (state_q == RUN) begin
      ALU_A             = a_word;
      ALU_B             = (op_q == OP_SUB || op_q == OP_CMP) ? ~b_word : b_word;
      ALU_IFlags[FlagC] = carry_q;
    end
  end

  always_comb begin
    flags_d        = '0;
    flags_d[FlagZ] = zero_q & ALU_OFlags[FlagZ];
    flags_d[FlagC] = ALU_OFlags[FlagC];
    flags_d[FlagN] = ALU_OFlags[FlagN];
    flags_d[FlagV] = ALU_OFlags[FlagV];
  end

  always_comb begin
    carry_start = 1'b0;
    case (op_t'(ReqOp))
      OP_ADC:         carry_start = CarryIn;
      OP_SUB, OP_CMP: carry_start = 1'b1;
      default:        carry_start = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            a_q     <= OpA;
            b_q     <= OpB;
            op_q    <= op_t'(ReqOp);
            idx_q   <= '0;
            carry_q <= carry_start;
            zero_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (op_q != OP_CMP) begin
            result_q[idx_q*DataWidth +: DataWidth] <= ALU_Y;
          end
          carry_q <= ALU_OFlags[FlagC];
          zero_q  <= zero_q & ALU_OFlags[FlagZ];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            flags_q <= flags_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ready      = (state_q == IDLE) || (state_q == DONE);
  assign Busy       = (state_q == RUN);
  assign Done       = (state_q == DONE);
  assign Result     = result_q;
  assign Flags      = flags_q;
  assign ALU_FuncOp = `ADD;

endmodule

// File: tb/tb_alu_mw_seq.sv
// Bench for alu_mw_seq: a behavioural 16-bit ALU, a table of directed vectors and
// hand-written sequences for Start-during-RUN, back-to-back and reset-abort cases.
module tb_alu_mw_seq;

  localparam int DW = 16;
  localparam int FB = 4;
  localparam int NW = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  logic              Clk = 1'b0;
  logic              nRst = 1'b0;
  logic              Start = 1'b0;
  logic [1:0]        ReqOp = 2'b00;
  logic              CarryIn = 1'b0;
  logic [NW*DW-1:0]  OpA = '0;
  logic [NW*DW-1:0]  OpB = '0;
  logic              Ready, Busy, Done;
  logic [NW*DW-1:0]  Result;
  logic [FB-1:0]     Flags;
  logic [DW-1:0]     ALU_A, ALU_B, ALU_Y;
  logic [FB-1:0]     ALU_IFlags, ALU_OFlags;
  logic [3:0]        ALU_FuncOp;
  logic [DW:0]       alu_sum;

  int n_checks = 0;
  int n_err    = 0;

  alu_mw_seq #(.DataWidth(DW), .FlagBits(FB), .Words(NW)) dut (
    .Clk(Clk), .nRst(nRst), .Start(Start), .ReqOp(ReqOp), .CarryIn(CarryIn),
    .OpA(OpA), .OpB(OpB), .Ready(Ready), .Busy(Busy), .Done(Done),
    .Result(Result), .Flags(Flags), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_IFlags(ALU_IFlags), .ALU_FuncOp(ALU_FuncOp), .ALU_Y(ALU_Y),
    .ALU_OFlags(ALU_OFlags)
  );

  always #5 Clk = ~Clk;

  // Shared ALU: Y = A + B + Cin, flags {V,N,C,Z}
  always_comb begin
    alu_sum    = {1'b0, ALU_A} + {1'b0, ALU_B} + {{DW{1'b0}}, ALU_IFlags[1]};
    ALU_Y      = alu_sum[DW-1:0];
    ALU_OFlags = {(ALU_A[DW-1] == ALU_B[DW-1]) && (alu_sum[DW-1] != ALU_A[DW-1]),
                  alu_sum[DW-1], alu_sum[DW], alu_sum[DW-1:0] == '0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request on a falling edge; returns on the falling edge after acceptance.
  task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic cin);
    @(negedge Clk);
    Start = 1'b1; ReqOp = op; OpA = a; OpB = b; CarryIn = cin;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // lat counts cycles after the accepting edge until Done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!Done && lat < 20) begin
      if (Busy) busy_n++;
      @(negedge Clk);
      lat++;
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, busy_n, dones;
    logic [63:0] seen_res;

    vecs[0] = '{"add_w0carry", OP_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
                64'h0000_0000_0001_0000, 4'b0000};
    vecs[1] = '{"add_allones", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h0, 4'b0011};
    vecs[2] = '{"adc_ovf",     OP_ADC, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                64'h8000_0000_0000_0000, 4'b1100};
    vecs[3] = '{"sub_borrow",  OP_SUB, 64'h0001_0000_0000_0000, 64'h1, 1'b0,
                64'h0000_FFFF_FFFF_FFFF, 4'b0010};
    vecs[4] = '{"add_ign_cin", OP_ADD, 64'h5, 64'h3, 1'b1,
                64'h8, 4'b0000};
    vecs[5] = '{"add_r",       OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0,
                64'h1234_5678_9ABC_DEF1, 4'b0000};
    vecs[6] = '{"cmp_eq",      OP_CMP, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
                64'h1234_5678_9ABC_DEF1, 4'b0011};
    vecs[7] = '{"cmp_w0diff",  OP_CMP, 64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF0, 1'b0,
                64'h1234_5678_9ABC_DEF1, 4'b0010};
    vecs[8] = '{"sub_0m1",     OP_SUB, 64'h0, 64'h1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};

    // Reset state
    #1;
    check("rst_ready", 64'(Ready), 64'd1);
    check("rst_busy",  64'(Busy),  64'd0);
    check("rst_done",  64'(Done),  64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_flags", 64'(Flags), 64'd0);
    check("rst_alu_a", 64'(ALU_A), 64'd0);
    @(negedge Clk);
    nRst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat, busy_n);
      check({vecs[i].name, "_result"}, Result, vecs[i].res);
      check({vecs[i].name, "_flags"}, 64'(Flags), 64'(vecs[i].flags));
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd5);
      check({vecs[i].name, "_busy"}, 64'(busy_n), 64'd4);
    end

    // Reset during RUN: abort with everything cleared immediately
    start_op(OP_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    @(negedge Clk);
    check("abort_running", 64'(Busy), 64'd1);
    nRst = 1'b0;
    #1;
    check("abort_busy",   64'(Busy),  64'd0);
    check("abort_done",   64'(Done),  64'd0);
    check("abort_ready",  64'(Ready), 64'd1);
    check("abort_result", Result, 64'd0);
    check("abort_flags",  64'(Flags), 64'd0);
    check("abort_alu",    {ALU_A, ALU_B, 28'd0, ALU_IFlags}, 64'd0);
    @(negedge Clk);
    nRst = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    start_op(OP_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_done(lat, busy_n);
    check("post_rst_result", Result, 64'h0000_0000_0001_0000);
    check("post_rst_lat", 64'(lat), 64'd5);

    // ALU drive in the first SUB word: inverted B, carry-in 1, opcode ADD
    start_op(OP_SUB, 64'h5, 64'h3, 1'b0);
    check("sub_alu_a",  64'(ALU_A), 64'h5);
    check("sub_alu_b",  64'(ALU_B), 64'hFFFC);
    check("sub_iflags", 64'(ALU_IFlags), 64'b0010);
    check("sub_funcop", 64'(ALU_FuncOp), 64'h0);
    wait_done(lat, busy_n);
    check("sub_small_result", Result, 64'h2);
    check("sub_small_flags", 64'(Flags), 64'b0010);
    @(negedge Clk);
    check("idle_alu", {ALU_A, ALU_B, 28'd0, ALU_IFlags}, 64'd0);

    // Start pulsed 2 cycles into RUN is ignored
    start_op(OP_ADD, 64'h100, 64'h200, 1'b0);
    @(negedge Clk);
    Start = 1'b1; ReqOp = OP_SUB; OpA = 64'hFFFF_FFFF_FFFF_FFFF; OpB = 64'h1;
    @(negedge Clk);
    Start = 1'b0;
    dones = 0;
    seen_res = '0;
    for (int i = 0; i < 12; i++) begin
      if (Done) begin
        dones++;
        seen_res = Result;
      end
      @(negedge Clk);
    end
    check("ignored_start_dones", 64'(dones), 64'd1);
    check("ignored_start_result", seen_res, 64'h300);

    // Start during DONE: back-to-back operation with no IDLE gap
    start_op(OP_ADD, 64'h1, 64'h2, 1'b0);
    wait_done(lat, busy_n);
    check("b2b_first_result", Result, 64'h3);
    Start = 1'b1; ReqOp = OP_ADD; OpA = 64'd10; OpB = 64'd20;
    @(negedge Clk);
    Start = 1'b0;
    check("b2b_no_gap", 64'(Busy), 64'd1);
    wait_done(lat, busy_n);
    check("b2b_spacing", 64'(lat), 64'd5);
    check("b2b_second_result", Result, 64'd30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mw_seq.md
Name: alu_mw_seq

Overview:
- Multi-word arithmetic sequencer. It performs Words×DataWidth add, add-with-carry, subtract and compare operations by driving the shared single-word ALU one word per cycle, least-significant word first.
- It chains the carry between words and aggregates the per-word flags.
- It sits between the execute-stage control and the ALU.
- It owns the ALU input ports for the whole of an operation.

Parameters:
- DataWidth, 16, ALU word width in bits.
- FlagBits, 4, ALU flag vector width. Bit order: Z=0, C=1, N=2, V=3.
- Words, 4, number of words per operand. Legal range is 2 or more.

Ports:
- Clk  in  1  system clock; all state is updated on the rising edge.
- nRst  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only while Ready=1.
- ReqOp  in  2  operation: 00 ADD, 01 ADC (uses CarryIn), 10 SUB, 11 CMP (flags only).
- CarryIn  in  1  carry input used by ADC only.
- OpA  in  Words*DataWidth  operand A; word 0 is bits [DataWidth-1:0].
- OpB  in  Words*DataWidth  operand B.
- Ready  out  1  1 when in IDLE or DONE; a Start can be accepted.
- Busy  out  1  1 while in RUN.
- Done  out  1  single-cycle pulse when the result and flags become valid.
- Result  out  Words*DataWidth  registered result.
- Flags  out  FlagBits  registered aggregate flags {V,N,C,Z}.
- ALU_A  out  DataWidth  current A word to the ALU.
- ALU_B  out  DataWidth  current B word to the ALU; inverted for SUB/CMP.
- ALU_IFlags  out  FlagBits  flags into the ALU; only the C bit is meaningful, all other bits are 0.
- ALU_FuncOp  out  4  ALU opcode; always `ADD from the shared opcode definitions.
- ALU_Y  in  DataWidth  ALU result, combinational from the ALU_* outputs.
- ALU_OFlags  in  FlagBits  ALU flags, combinational.

Behaviour:
- Reset (nRst=0, asynchronous):
  - state=IDLE; word index=0.
  - Busy=0, Done=0, Ready=1.
  - Result=0, Flags=0.
  - ALU_A=ALU_B=0, ALU_IFlags=0.
  - Latched operands and chain carry cleared.
  - Reset asserted during RUN aborts the operation with no Done.
- States: IDLE -> RUN -> DONE -> IDLE.
  - IDLE/DONE with Start=1: latch OpA, OpB, ReqOp; set index=0; set chain carry (ADD 0, ADC CarryIn, SUB/CMP 1); go to RUN.
  - DONE without Start returns to IDLE. DONE with Start goes directly to RUN, giving back-to-back operations.
  - Start while in RUN is ignored and is not queued.
- RUN, one word per cycle:
  - ALU_A = A word[index].
  - ALU_B = B word[index], or ~B word[index] for SUB/CMP.
  - ALU_IFlags[C] = chain carry.
  - ALU_FuncOp is always `ADD. Subtraction is realised as A + ~B + 1, because the ALU's SUB op ignores carry-in.
  - On each edge: capture ALU_Y into result word[index] (suppressed for CMP); chain carry <= ALU_OFlags[C]; accumulate zero = zero AND ALU_OFlags[Z]; index++.
  - When index==Words-1 the edge also loads Flags and goes to DONE:
    - Z = accumulated zero across all words.
    - C, N, V = ALU_OFlags of the top word.
- Outputs and timing:
  - Result is written word-by-word directly into the output register. Result is only guaranteed coherent while Done=1 or Ready=1.
  - CMP leaves Result holding its previous value.
  - Done=1 for exactly the one cycle in DONE. Latency: Start edge to Done = Words+1 edges; Done is visible in cycle Words+1 after the accepting edge.
  - Busy=1 exactly for Words cycles.
  - Flags and Result hold until the next operation writes them.
- Flag semantics:
  - SUB/CMP: C=1 means no borrow (A ≥ B unsigned).
  - V is signed overflow of the full-width operation. It is correct because ALU_B already carries ~B.
- Idle outputs: outside RUN, ALU_A, ALU_B and ALU_IFlags are 0.
- Index counter width is $clog2(Words); wrap-around is never reached because RUN exits at Words-1.

Test Plan (Words=4, DataWidth=16):
- ADD 0x0000_0000_0000_FFFF + 0x0000_0000_0000_0001 -> Result 0x0000_0000_0001_0000, Flags Z0 C0 N0 V0, Done 5 edges after Start, Busy high for 4 cycles.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> Result 0, Z=1 C=1 N=0 V=0. Also ADC 0x7FFF_FFFF_FFFF_FFFF + 0 with CarryIn=1 -> 0x8000_0000_0000_0000, N=1 V=1 C=0.
- SUB 0x0001_0000_0000_0000 - 1 -> 0x0000_FFFF_FFFF_FFFF, C=1 N=0. SUB 0 - 1 -> 0xFFFF_FFFF_FFFF_FFFF, C=0 N=1 Z=0.
- CMP 0x1234_5678_9ABC_DEF0 vs the same value after a prior ADD left Result=R -> Flags Z=1 C=1, Result still R. CMP of values differing only in word 0 -> Z=0.
- Start pulsed again 2 cycles into RUN -> ignored, single Done. Start held during DONE -> next op starts with no IDLE gap, back-to-back Done pulses 5 cycles apart.
- nRst low at cycle 2 of RUN -> Busy, Done, Result, Flags and ALU_* outputs all 0 immediately; after release Ready=1 and a new ADD completes correctly.
